// File: rtl/rom_scan_stats.sv
// Windowed max/min scanner in front of an external synchronous-read ROM.
// One address per cycle; read data is realigned with its address through an RD_LAT-deep valid pipe.
module rom_scan_stats #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 1,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              res_valid,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] max_val,
  output logic [ADDR_W-1:0] max_addr,
  output logic [DATA_W-1:0] min_val,
  output logic [ADDR_W-1:0] min_addr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic              busy_q, busy_d;
  logic              res_valid_q, res_valid_d;
  logic              len_nz_q, len_nz_d;
  logic              seen_q, seen_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] max_val_q, max_val_d;
  logic [ADDR_W-1:0] max_addr_q, max_addr_d;
  logic [DATA_W-1:0] min_val_q, min_val_d;
  logic [ADDR_W-1:0] min_addr_q, min_addr_d;
  logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [ADDR_W-1:0] pipe_addr_q [RD_LAT];
  logic [ADDR_W-1:0] pipe_addr_d [RD_LAT];

  logic              issue;
  logic              samp_vld;
  logic [ADDR_W-1:0] samp_addr;
  logic              samp_gt;
  logic              samp_lt;

  assign issue     = (state_q == S_FETCH);
  assign samp_vld  = pipe_vld_q[RD_LAT-1];
  assign samp_addr = pipe_addr_q[RD_LAT-1];

  always_comb begin
    if (SIGNED != 0) begin
      samp_gt = $signed(rom_data) > $signed(max_val_q);
      samp_lt = $signed(rom_data) < $signed(min_val_q);
    end else begin
      samp_gt = rom_data > max_val_q;
      samp_lt = rom_data < min_val_q;
    end
  end

  // Stage 0 captures the address being presented this cycle; the last stage lines up with rom_data.
  always_comb begin
    pipe_vld_d = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      pipe_addr_d[i] = pipe_addr_q[i];
    end
    pipe_vld_d[0]  = issue;
    pipe_addr_d[0] = rom_addr_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
    end
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    res_valid_d = res_valid_q;
    len_nz_d    = len_nz_q;
    seen_d      = seen_q;
    rom_addr_d  = rom_addr_q;
    rem_d       = rem_q;
    max_val_d   = max_val_q;
    max_addr_d  = max_addr_q;
    min_val_d   = min_val_q;
    min_addr_d  = min_addr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d   = 1'b1;
          len_nz_d = (len != '0);
          if (len != '0) begin
            rem_d       = len;
            rom_addr_d  = base_addr;
            res_valid_d = 1'b0;
            seen_d      = 1'b0;
            state_d     = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        rem_d = rem_q - REM_ONE;
        // The final address stays on the bus; the window wraps naturally at the top.
        if (rem_q == REM_ONE) begin
          state_d = S_DRAIN;
        end else begin
          rom_addr_d = rom_addr_q + ADDR_ONE;
        end
      end
      S_DRAIN: begin
        if (pipe_vld_q == '0) begin
          state_d = S_DONE;
        end
      end
      default: begin
        busy_d = 1'b0;
        if (len_nz_q) begin
          res_valid_d = 1'b1;
        end
        state_d = S_IDLE;
      end
    endcase

    // Strict compares keep the earliest address on ties.
    if (samp_vld) begin
      seen_d = 1'b1;
      if (!seen_q || samp_gt) begin
        max_val_d  = rom_data;
        max_addr_d = samp_addr;
      end
      if (!seen_q || samp_lt) begin
        min_val_d  = rom_data;
        min_addr_d = samp_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      len_nz_q    <= 1'b0;
      seen_q      <= 1'b0;
      rom_addr_q  <= '0;
      rem_q       <= '0;
      max_val_q   <= '0;
      max_addr_q  <= '0;
      min_val_q   <= '0;
      min_addr_q  <= '0;
      pipe_vld_q  <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_addr_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      len_nz_q    <= len_nz_d;
      seen_q      <= seen_d;
      rom_addr_q  <= rom_addr_d;
      rem_q       <= rem_d;
      max_val_q   <= max_val_d;
      max_addr_q  <= max_addr_d;
      min_val_q   <= min_val_d;
      min_addr_q  <= min_addr_d;
      pipe_vld_q  <= pipe_vld_d;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_addr_q[i] <= pipe_addr_d[i];
      end
    end
  end

  assign busy      = busy_q;
  assign done      = (state_q == S_DONE);
  assign res_valid = res_valid_q;
  assign rom_addr  = rom_addr_q;
  assign max_val   = max_val_q;
  assign max_addr  = max_addr_q;
  assign min_val   = min_val_q;
  assign min_addr  = min_addr_q;

endmodule
